mmv_quota_arbitrator: RTL and testbench
=======================================

Name: mmv_quota_arbitrator

Overview:
- Arbiter that shares one MemoryMapped slave with arbitrary read latency between MASTERS masters.
- Round-robin ownership with a per-grant transaction quota: an owner keeps the bus for up to QUOTA accepted transactions, then rotation is forced.
- Tracks outstanding reads in an internal in-order tag queue and routes returned read data to the issuing master.
- Flags protocol violations from the slave side.

Parameters:
- AWIDTH, 8, address width
- DWIDTH, 8, data width
- MASTERS, 2, number of masters (>1)
- RDPENDS, 4, max outstanding reads (>=1)
- QUOTA, 4, max accepted transactions per grant (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- s_addr  in  [MASTERS-1:0][AWIDTH-1:0]  master addresses
- s_wreq  in  [MASTERS-1:0]  write requests
- s_wdat  in  [MASTERS-1:0][DWIDTH-1:0]  write data
- s_rreq  in  [MASTERS-1:0]  read requests
- s_rdat  out  [MASTERS-1:0][DWIDTH-1:0]  read data, m_rdat fanned out to all masters
- s_rval  out  [MASTERS-1:0]  read data valid, per master
- s_busy  out  [MASTERS-1:0]  stall to each master
- m_addr  out  AWIDTH  slave address
- m_wreq  out  1  slave write
- m_wdat  out  DWIDTH  slave write data
- m_rreq  out  1  slave read
- m_rdat  in  DWIDTH  slave read data
- m_rval  in  1  slave read valid
- m_busy  in  1  slave stall
- pend_cnt  out  $clog2(RDPENDS+1)  outstanding reads
- err  out  1  sticky: m_rval received with no read outstanding

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr pointer=0, quota count=0, tag queue empty, pend_cnt=0, err=0.
- Output values in IDLE: s_busy all 1; m_wreq=m_rreq=0; m_addr=m_wdat=0; s_rval=0.
- request[i] = s_wreq[i] | s_rreq[i].
- IDLE:
  - If any request is set, owner <= first requester searching from pointer upward with wrap; go to OWN; quota count <= 0.
  - Arbitration latency is 1 cycle: the grant becomes visible the cycle after the request is seen.
- OWN:
  - m_addr/m_wdat/m_wreq come from the owner.
  - m_rreq = s_rreq[owner] & ~qfull, where qfull = (pend_cnt==RDPENDS).
  - s_busy[owner] = m_busy | (s_rreq[owner] & qfull); every non-owner has s_busy=1.
  - accept = (m_wreq | m_rreq) & ~m_busy.
  - A master asserting s_wreq and s_rreq together is forwarded unchanged and counts as one transaction.
  - On accept: quota count += 1.
  - Go to IDLE when request[owner]==0, or when accept occurs with quota count==QUOTA-1.
  - On leaving OWN, pointer <= owner+1 (mod MASTERS).
  - While m_busy=1 the owner is held; nothing is counted.
- Tag queue (circular buffer, RDPENDS entries of owner index):
  - Push on accept with m_rreq=1.
  - Pop on m_rval when not empty.
  - s_rval[i] = m_rval & ~empty & (head==i).
  - Responses are strictly in order.
  - qfull does not look at m_rval. No combinational path from m_rval to m_rreq or s_busy; a slot freed by a pop is usable the next cycle.
  - Simultaneous push and pop: pend_cnt unchanged, pointers advance.
- m_rval while the queue is empty, including the same cycle as a push: no s_rval, queue unchanged, err <= 1 until reset.
- Reset mid-operation discards all tags. Later m_rval pulses for pre-reset reads set err.
- pend_cnt is a registered occupancy count and saturates at RDPENDS by construction.

Test Plan:
- QUOTA=4, master0 does 6 back-to-back writes, master1 idle, m_busy=0 -> writes 1-4 accepted on consecutive cycles; 1 IDLE cycle with m_wreq=0; master0 regranted; writes 5-6 accepted; pointer ends at 1.
- Both masters request writes continuously -> m_wreq pattern 4 from master0, 1 gap, 4 from master1, 1 gap, repeating; s_busy[non-owner]=1 throughout.
- RDPENDS=4, slave latency 5, master0 issues 6 reads -> reads 1-4 accepted; 5th sees s_busy=1 until the cycle after the first m_rval; pend_cnt peaks at 4; 6 s_rval[0] pulses in order.
- Alternate ownership QUOTA=1, reads m0,m1,m0 outstanding, slave returns A,B,C -> s_rval[0] on A, s_rval[1] on B, s_rval[0] on C; s_rdat carries the matching data.
- Owner read with m_busy=1 for 3 cycles -> s_busy[owner]=1, quota count and pend_cnt unchanged, accept on 4th cycle.
- Single m_rval with pend_cnt=0 -> err=1 stays set, s_rval=0. Then reset low mid-burst with 2 reads pending -> pend_cnt=0, s_busy all 1 immediately; later m_rval sets err.

Source files
------------

// File: rtl/mmv_quota_arbitrator.sv
// Round-robin arbiter sharing one memory-mapped slave between MASTERS masters,
// with a per-grant transaction quota and an in-order tag queue for read returns.
module mmv_quota_arbitrator #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int MASTERS = 2,
  parameter int RDPENDS = 4,
  parameter int QUOTA   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTERS-1:0][AWIDTH-1:0]    s_addr,
  input  logic [MASTERS-1:0]                s_wreq,
  input  logic [MASTERS-1:0][DWIDTH-1:0]    s_wdat,
  input  logic [MASTERS-1:0]                s_rreq,
  output logic [MASTERS-1:0][DWIDTH-1:0]    s_rdat,
  output logic [MASTERS-1:0]                s_rval,
  output logic [MASTERS-1:0]                s_busy,
  output logic [AWIDTH-1:0]                 m_addr,
  output logic                              m_wreq,
  output logic [DWIDTH-1:0]                 m_wdat,
  output logic                              m_rreq,
  input  logic [DWIDTH-1:0]                 m_rdat,
  input  logic                              m_rval,
  input  logic                              m_busy,
  output logic [$clog2(RDPENDS+1)-1:0]      pend_cnt,
  output logic                              err
);

  localparam int OW = $clog2(MASTERS);
  localparam int PW = (RDPENDS > 1) ? $clog2(RDPENDS) : 1;
  localparam int QW = (QUOTA > 1) ? $clog2(QUOTA) : 1;
  localparam int CW = $clog2(RDPENDS+1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       ptr;
  logic [OW-1:0]       pick;
  logic [QW-1:0]       qcnt;
  logic [OW-1:0]       tags [RDPENDS];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [MASTERS-1:0]  req;
  logic                any_req;
  logic                owner_req;
  logic                qfull;
  logic                empty;
  logic                accept;
  logic                push;
  logic                pop;
  logic                last_txn;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(RDPENDS-1)) ? '0 : p + 1'b1;
  endfunction

  assign req      = s_wreq | s_rreq;
  assign qfull    = (pend_cnt == CW'(RDPENDS));
  assign empty    = (pend_cnt == '0);
  assign accept   = (m_wreq | m_rreq) & ~m_busy;
  assign push     = accept & m_rreq;
  assign pop      = m_rval & ~empty;
  assign last_txn = (qcnt == QW'(QUOTA-1));
  assign s_rdat   = {MASTERS{m_rdat}};

  // First requester at or above the rotation pointer, wrapping around.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      if (!any_req && req[(32'(ptr) + k) % MASTERS]) begin
        pick    = OW'((32'(ptr) + k) % MASTERS);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    s_busy    = '1;
    m_addr    = '0;
    m_wdat    = '0;
    m_wreq    = 1'b0;
    m_rreq    = 1'b0;
    owner_req = 1'b0;
    if (state == OWN) begin
      m_addr         = s_addr[owner];
      m_wdat         = s_wdat[owner];
      m_wreq         = s_wreq[owner];
      m_rreq         = s_rreq[owner] & ~qfull;
      s_busy[owner]  = m_busy | (s_rreq[owner] & qfull);
      owner_req      = req[owner];
    end
  end

  // Read returns are routed whatever the grant state; reads outlive their grant.
  always_comb begin
    s_rval = '0;
    if (pop) s_rval[tags[head]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      qcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= pick;
            qcnt  <= '0;
            state <= OWN;
          end
        end
        OWN: begin
          if (accept) qcnt <= qcnt + 1'b1;
          if (!owner_req || (accept && last_txn)) begin
            state <= IDLE;
            ptr   <= (owner == OW'(MASTERS-1)) ? '0 : owner + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (push) tail <= wrap_inc(tail);
      if (pop)  head <= wrap_inc(head);
      if (push && !pop)      pend_cnt <= pend_cnt + 1'b1;
      else if (pop && !push) pend_cnt <= pend_cnt - 1'b1;
      if (m_rval && empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tags[tail] <= owner;
  end

endmodule

// File: tb/tb_mmv_quota_arbitrator.sv
// Bench for mmv_quota_arbitrator: directed table, hand-written read/stall/reset
// sequences, and random traffic against a queue-based reference model.
module tb_mmv_quota_arbitrator;

  localparam int M   = 2;
  localparam int RDP = 4;
  localparam int QT  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [M-1:0][7:0]   s_addr;
  logic [M-1:0]        s_wreq;
  logic [M-1:0][7:0]   s_wdat;
  logic [M-1:0]        s_rreq;
  logic [M-1:0][7:0]   s_rdat;
  logic [M-1:0]        s_rval;
  logic [M-1:0]        s_busy;
  logic [7:0]          m_addr;
  logic                m_wreq;
  logic [7:0]          m_wdat;
  logic                m_rreq;
  logic [7:0]          m_rdat;
  logic                m_rval;
  logic                m_busy;
  logic [2:0]          pend_cnt;
  logic                err;

  mmv_quota_arbitrator #(
    .AWIDTH(8), .DWIDTH(8), .MASTERS(M), .RDPENDS(RDP), .QUOTA(QT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_addr(s_addr), .s_wreq(s_wreq), .s_wdat(s_wdat), .s_rreq(s_rreq),
    .s_rdat(s_rdat), .s_rval(s_rval), .s_busy(s_busy),
    .m_addr(m_addr), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
    .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy),
    .pend_cnt(pend_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  int  md_owner;
  int  md_ptr;
  int  md_cnt;
  int  md_q[$];
  bit  md_err;

  logic              e_mw, e_mr, e_acc, e_err;
  logic [7:0]        e_addr, e_wdat;
  logic [M-1:0]      e_sbusy, e_srval;
  logic [M-1:0][7:0] e_rdat;
  int                e_pend;

  // values sampled at the last checked cycle
  logic              last_mw, last_mr, last_mrval, last_err;
  logic [7:0]        last_addr;
  logic [M-1:0]      last_sbusy, last_srval;
  logic [M-1:0][7:0] last_rdat;
  int                last_pend, last_cyc;

  // slave emulation for the latency test
  bit  slave_en = 0;
  int  sl_lat   = 5;
  int  sl_n     = 0;
  int  sl_due[$];
  int  sl_dat[$];

  typedef struct {
    logic       w0, w1;
    logic [1:0] sb;
    logic       mw;
    logic [7:0] addr;
  } vec_t;
  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    md_owner = -1;
    md_ptr   = 0;
    md_cnt   = 0;
    md_q.delete();
    md_err   = 0;
  endtask

  task automatic model_eval();
    int o;
    bit qfull;
    o       = md_owner;
    qfull   = (md_q.size() == RDP);
    e_sbusy = '1;
    e_mw    = 0;
    e_mr    = 0;
    e_addr  = 0;
    e_wdat  = 0;
    if (o >= 0) begin
      e_mw       = s_wreq[o];
      e_mr       = s_rreq[o] && !qfull;
      e_addr     = s_addr[o];
      e_wdat     = s_wdat[o];
      e_sbusy[o] = m_busy | (s_rreq[o] && qfull);
    end
    e_srval = '0;
    if (m_rval && md_q.size() > 0) e_srval[md_q[0]] = 1'b1;
    e_rdat = {M{m_rdat}};
    e_pend = md_q.size();
    e_err  = md_err;
    e_acc  = (e_mw | e_mr) && !m_busy;
  endtask

  task automatic model_advance();
    int  o;
    bit  at_quota;
    o = md_owner;
    if (m_rval) begin
      if (md_q.size() == 0) md_err = 1;
      else void'(md_q.pop_front());
    end
    if (e_acc && e_mr) md_q.push_back(o);
    if (o < 0) begin
      for (int k = 0; k < M; k++) begin
        int idx;
        idx = (md_ptr + k) % M;
        if (s_wreq[idx] | s_rreq[idx]) begin
          md_owner = idx;
          md_cnt   = 0;
          break;
        end
      end
    end else begin
      at_quota = (md_cnt == QT - 1);
      if (e_acc) md_cnt++;
      if (!(s_wreq[o] | s_rreq[o]) || (e_acc && at_quota)) begin
        md_ptr   = (o + 1) % M;
        md_owner = -1;
      end
    end
  endtask

  // Inputs are set by the caller just after a rising edge; checks happen on the falling edge.
  task automatic cycle();
    if (slave_en) begin
      if (sl_due.size() > 0 && sl_due[0] <= cyc) begin
        m_rval = 1'b1;
        m_rdat = 8'(sl_dat[0]);
        void'(sl_due.pop_front());
        void'(sl_dat.pop_front());
      end else begin
        m_rval = 1'b0;
      end
    end
    @(negedge clk);
    model_eval();
    check("m_wreq",   64'(m_wreq),   64'(e_mw));
    check("m_rreq",   64'(m_rreq),   64'(e_mr));
    check("m_addr",   64'(m_addr),   64'(e_addr));
    check("m_wdat",   64'(m_wdat),   64'(e_wdat));
    check("s_busy",   64'(s_busy),   64'(e_sbusy));
    check("s_rval",   64'(s_rval),   64'(e_srval));
    check("s_rdat",   64'(s_rdat),   64'(e_rdat));
    check("pend_cnt", 64'(pend_cnt), 64'(e_pend));
    check("err",      64'(err),      64'(e_err));
    last_mw    = m_wreq;
    last_mr    = m_rreq;
    last_addr  = m_addr;
    last_sbusy = s_busy;
    last_srval = s_rval;
    last_rdat  = s_rdat;
    last_pend  = int'(pend_cnt);
    last_err   = err;
    last_mrval = m_rval;
    last_cyc   = cyc;
    model_advance();
    if (slave_en && e_acc && e_mr) begin
      sl_due.push_back(cyc + sl_lat);
      sl_dat.push_back(sl_n);
      sl_n++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    s_wreq = '0;
    s_rreq = '0;
    m_rval = 1'b0;
    m_busy = 1'b0;
    #2;
    check("rst_pend",  64'(pend_cnt), 64'(0));
    check("rst_err",   64'(err), 64'(0));
    check("rst_sbusy", 64'(s_busy), 64'(2'b11));
    check("rst_mreq",  64'({m_wreq, m_rreq}), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic issue_read(input int m);
    bit done;
    done = 0;
    s_rreq[m] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_mr && !m_busy;
    end
    check("read_grant_timeout", 64'(done), 64'(1));
    s_rreq[m] = 1'b0;
    cycle();
  endtask

  task automatic set_v(input int i, input logic w0, input logic w1, input logic [1:0] sb,
                       input logic mw, input logic [7:0] addr);
    tbl[i] = '{w0, w1, sb, mw, addr};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int accepts, pulses, maxp, first_rval, acc5;
    reset  = 1'b0;
    s_addr = '0;
    s_wdat = '0;
    s_wreq = '0;
    s_rreq = '0;
    m_rdat = '0;
    m_rval = 1'b0;
    m_busy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // quota rotation: m0 alone for 9 cycles, then both masters
    set_v(0, 1, 0, 2'b11, 0, 8'h00);
    for (int i = 1; i <= 4; i++) set_v(i, 1, 0, 2'b10, 1, 8'hA0);
    set_v(5, 1, 0, 2'b11, 0, 8'h00);
    set_v(6, 1, 0, 2'b10, 1, 8'hA0);
    set_v(7, 1, 0, 2'b10, 1, 8'hA0);
    set_v(8, 0, 0, 2'b10, 0, 8'hA0);
    set_v(9, 0, 0, 2'b11, 0, 8'h00);
    set_v(10, 1, 1, 2'b11, 0, 8'h00);
    for (int i = 11; i <= 14; i++) set_v(i, 1, 1, 2'b01, 1, 8'hB1);
    set_v(15, 1, 1, 2'b11, 0, 8'h00);
    for (int i = 16; i <= 19; i++) set_v(i, 1, 1, 2'b10, 1, 8'hA0);
    set_v(20, 1, 1, 2'b11, 0, 8'h00);

    s_addr[0] = 8'hA0;
    s_addr[1] = 8'hB1;
    s_wdat[0] = 8'h11;
    s_wdat[1] = 8'h22;
    for (int i = 0; i < 21; i++) begin
      s_wreq = {tbl[i].w1, tbl[i].w0};
      cycle();
      check("tbl_sbusy", 64'(last_sbusy), 64'(tbl[i].sb));
      check("tbl_mwreq", 64'(last_mw), 64'(tbl[i].mw));
      check("tbl_maddr", 64'(last_addr), 64'(tbl[i].addr));
    end
    do_reset();

    // read routing across ownership changes
    issue_read(0);
    issue_read(1);
    issue_read(0);
    check("order_pend3", 64'(pend_cnt), 64'(3));
    m_rval = 1'b1;
    m_rdat = 8'hA1;
    cycle();
    check("order_rval_a", 64'(last_srval), 64'(2'b01));
    check("order_rdat_a", 64'(last_rdat[0]), 64'(8'hA1));
    m_rdat = 8'hB2;
    cycle();
    check("order_rval_b", 64'(last_srval), 64'(2'b10));
    check("order_rdat_b", 64'(last_rdat[1]), 64'(8'hB2));
    m_rdat = 8'hC3;
    cycle();
    check("order_rval_c", 64'(last_srval), 64'(2'b01));
    check("order_rdat_c", 64'(last_rdat[0]), 64'(8'hC3));
    m_rval = 1'b0;
    cycle();
    check("order_empty", 64'(last_pend), 64'(0));
    do_reset();

    // slave stall on a read for three cycles
    s_rreq[0] = 1'b1;
    m_busy    = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_sbusy", 64'(last_sbusy[0]), 64'(1));
      check("stall_pend", 64'(last_pend), 64'(0));
    end
    m_busy = 1'b0;
    cycle();
    check("stall_accept_rreq", 64'(last_mr), 64'(1));
    check("stall_accept_sbusy", 64'(last_sbusy[0]), 64'(0));
    s_rreq[0] = 1'b0;
    cycle();
    check("stall_pend_after", 64'(last_pend), 64'(1));
    m_rval = 1'b1;
    cycle();
    m_rval = 1'b0;
    do_reset();

    // six reads against a fixed-latency slave with a full tag queue
    slave_en   = 1;
    sl_lat     = 5;
    sl_n       = 0;
    accepts    = 0;
    pulses     = 0;
    maxp       = 0;
    first_rval = -1;
    acc5       = -1;
    s_rreq[0]  = 1'b1;
    for (int i = 0; i < 120 && pulses < 6; i++) begin
      if (accepts >= 6) s_rreq[0] = 1'b0;
      cycle();
      if (last_pend > maxp) maxp = last_pend;
      if (last_mrval && first_rval < 0) first_rval = last_cyc;
      if (last_mr && !m_busy) begin
        accepts++;
        if (accepts == 5) acc5 = last_cyc;
      end
      if (last_srval[0]) begin
        check("lat_rdat_order", 64'(last_rdat[0]), 64'(pulses));
        pulses++;
      end
    end
    slave_en  = 0;
    m_rval    = 1'b0;
    s_rreq[0] = 1'b0;
    check("lat_accepts", 64'(accepts), 64'(6));
    check("lat_pulses", 64'(pulses), 64'(6));
    check("lat_pend_peak", 64'(maxp), 64'(4));
    check("lat_fifth_after_rval", 64'(acc5 - first_rval), 64'(1));
    do_reset();

    // spurious return, then reset with reads in flight
    m_rval = 1'b1;
    m_rdat = 8'h5A;
    cycle();
    check("err_no_srval", 64'(last_srval), 64'(0));
    m_rval = 1'b0;
    cycle();
    cycle();
    check("err_sticky", 64'(err), 64'(1));
    issue_read(0);
    issue_read(0);
    check("err_pend2", 64'(pend_cnt), 64'(2));
    do_reset();
    m_rval = 1'b1;
    cycle();
    m_rval = 1'b0;
    cycle();
    check("err_stale_return", 64'(last_err), 64'(1));
    do_reset();

    // random traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      s_wreq    = 2'($urandom);
      s_rreq    = 2'($urandom);
      s_addr    = 16'($urandom);
      s_wdat    = 16'($urandom);
      m_busy    = ($urandom_range(3) == 0);
      m_rval    = ($urandom_range(2) == 0);
      m_rdat    = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
